// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame sequencer: start/data/stop framing with a single-entry valid/ready byte holding register.
// Optional even-parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame_ctrl #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxck,
  input  logic       rxsdo,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frm_err,
  output logic       ovr_err,
  output logic       to_err,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshake: a byte transfers in every cycle where rx_valid && rx_ready; rx_valid
  // stays high and rx_data stays stable until that happens.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic             rxck_q;
  logic             stb;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frm_err_q, frm_err_d;
  logic             ovr_err_q, ovr_err_d;
  logic             to_err_q, to_err_d;
  logic             busy_q, busy_d;
  logic             complete;
  logic             frame_ok;

`ifdef UART_RX_PARITY_EN
  logic             par_err_q, par_err_d;
  assign frame_ok = rxsdo & ~par_err_q;
`else
  assign frame_ok = rxsdo;
`endif

  assign stb = rxck_q & ~rxck;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    frm_err_d  = 1'b0;
    ovr_err_d  = 1'b0;
    to_err_d   = 1'b0;
    complete   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
`endif

    if (stb || state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != '1) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (stb && !rxsdo) begin
          state_d  = DATA;
          bitcnt_d = 3'd0;
        end
      end
      DATA: begin
        if (stb) begin
          shift_d  = {rxsdo, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (stb) begin
          par_err_d = ^{shift_q, rxsdo};
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (stb) begin
          state_d = IDLE;
          if (frame_ok) complete  = 1'b1;
          else          frm_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe on the terminal count keeps the frame alive.
    if (!stb && state_q != IDLE && to_cnt_q == TO_LAST) begin
      state_d  = IDLE;
      to_err_d = 1'b1;
    end

    if (complete && (!rx_valid_q || rx_ready)) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else begin
      if (complete)               ovr_err_d  = 1'b1;
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rxck_q     <= 1'b1;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'd0;
      to_cnt_q   <= '0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
      to_err_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rxck_q     <= rxck;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frm_err_q  <= frm_err_d;
      ovr_err_q  <= ovr_err_d;
      to_err_q   <= to_err_d;
      busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frm_err   = frm_err_q;
  assign ovr_err   = ovr_err_q;
  assign to_err    = to_err_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: framing, overrun, timeout, reset and optional parity.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxck;
  logic       rxsdo;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frm_err;
  logic       ovr_err;
  logic       to_err;
  logic       busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int frm_cnt  = 0;
  int ovr_cnt  = 0;
  int to_cnt   = 0;

  logic [7:0] exp_q[$];

  logic       snap_valid, snap_valid2, snap_frm, snap_ovr;
  logic [7:0] snap_data;

  localparam int BIT = 64;

  uart_rx_frame_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .rxck      (rxck),
    .rxsdo     (rxsdo),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frm_err   (frm_err),
    .ovr_err   (ovr_err),
    .to_err    (to_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers: inputs change 2 ns after the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b, input int cyc);
    rxsdo = b;
    rxck  = 1'b1;
    tick(cyc / 2);
    rxck  = 1'b0;
    tick(cyc - cyc / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int cyc, input logic rdy_pulse);
    logic [10:0] bits;
    int nb;
`ifdef UART_RX_PARITY_EN
    bits = {stop, par, b, 1'b0};
    nb   = 11;
`else
    bits = {par, stop, b, 1'b0};
    nb   = 10;
`endif
    for (int i = 0; i < nb - 1; i++) send_bit(bits[i], cyc);
    rxsdo = bits[nb-1];
    rxck  = 1'b1;
    tick(cyc / 2);
    rxck  = 1'b0;
    if (rdy_pulse) rx_ready = 1'b1;
    tick(1);
    snap_valid = rx_valid;
    snap_data  = rx_data;
    snap_frm   = frm_err;
    snap_ovr   = ovr_err;
    if (rdy_pulse) rx_ready = 1'b0;
    tick(1);
    snap_valid2 = rx_valid;
    tick(cyc - cyc / 2 - 2);
  endtask

  // scoreboard / pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (frm_err) frm_cnt++;
      if (ovr_err) ovr_cnt++;
      if (to_err)  to_cnt++;
      if (frm_err || ovr_err || to_err)
        check("err_onehot", 32'(frm_err) + 32'(ovr_err) + 32'(to_err), 32'd1);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("sb_pop_empty", exp_q.size(), 32'd1);
        else                   check("sb_data", rx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst      = 1'b0;
    rxck     = 1'b1;
    rxsdo    = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_errs", {frm_err, ovr_err, to_err}, 3'b000);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b1;
    tick(4);

    // nominal byte at a realistic bit period
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, ^8'hA5, 1'b1, 1041, 1'b0);
    check("a5_valid", snap_valid, 1'b1);
    check("a5_data", snap_data, 8'hA5);
    check("a5_valid_drop", snap_valid2, 1'b0);
    check("a5_no_err", frm_cnt + ovr_cnt + to_cnt, 32'd0);
    check("a5_busy", busy, 1'b0);

    // bad stop bit, then a clean frame
    send_frame(8'h3C, ^8'h3C, 1'b0, BIT, 1'b0);
    check("3c_frm", snap_frm, 1'b1);
    check("3c_valid", snap_valid, 1'b0);
    check("3c_frm_cnt", frm_cnt, 32'd1);
    exp_q.push_back(8'h55);
    send_frame(8'h55, ^8'h55, 1'b1, BIT, 1'b0);
    check("55_valid", snap_valid, 1'b1);
    check("55_data", snap_data, 8'h55);

    // overrun: consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, ^8'h11, 1'b1, BIT, 1'b0);
    check("11_valid", snap_valid2, 1'b1);
    check("11_data", snap_data, 8'h11);
    send_frame(8'h22, ^8'h22, 1'b1, BIT, 1'b0);
    check("ovr_pulse", snap_ovr, 1'b1);
    check("ovr_keep_data", snap_data, 8'h11);
    check("ovr_keep_valid", snap_valid, 1'b1);
    check("ovr_cnt", ovr_cnt, 32'd1);

    // pop coincides with load
    exp_q.push_back(8'h22);
    send_frame(8'h22, ^8'h22, 1'b1, BIT, 1'b1);
    check("swap_valid", snap_valid, 1'b1);
    check("swap_data", snap_data, 8'h22);
    check("swap_no_ovr", snap_ovr, 1'b0);
    check("swap_ovr_cnt", ovr_cnt, 32'd1);
    rx_ready = 1'b1;
    tick(2);
    check("swap_drained", rx_valid, 1'b0);

    // timeout after start + 3 data bits
    send_bit(1'b0, BIT);
    send_bit(1'b1, BIT);
    send_bit(1'b0, BIT);
    rxsdo = 1'b1;
    rxck  = 1'b1;
    tick(BIT / 2);
    rxck  = 1'b0;
    tick(1);
    tick(4095);
    check("to_early", to_err, 1'b0);
    check("to_busy_before", busy, 1'b1);
    tick(1);
    check("to_pulse", to_err, 1'b1);
    check("to_busy_after", busy, 1'b0);
    check("to_state", dbg_state, 2'd0);
    tick(1);
    check("to_single", to_err, 1'b0);
    check("to_cnt", to_cnt, 32'd1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, ^8'h81, 1'b1, BIT, 1'b0);
    check("81_valid", snap_valid, 1'b1);
    check("81_data", snap_data, 8'h81);

    // reset mid-DATA
    send_bit(1'b0, BIT);
    send_bit(1'b1, BIT);
    send_bit(1'b1, BIT);
    check("mid_busy", busy, 1'b1);
    check("mid_state", dbg_state, 2'd1);
    rst = 1'b0;
    tick(1);
    check("mrst_rx_data", rx_data, 8'h00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_valid", rx_valid, 1'b0);
    check("mrst_state", dbg_state, 2'd0);
    rxck  = 1'b1;
    rxsdo = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(4);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, ^8'hF0, 1'b1, BIT, 1'b0);
    check("f0_valid", snap_valid, 1'b1);
    check("f0_data", snap_data, 8'hF0);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, BIT, 1'b0);
    check("par_ok_valid", snap_valid, 1'b1);
    check("par_ok_data", snap_data, 8'h07);
    send_frame(8'h07, 1'b0, 1'b1, BIT, 1'b0);
    check("par_bad_frm", snap_frm, 1'b1);
    check("par_bad_valid", snap_valid, 1'b0);
    check("frm_total", frm_cnt, 32'd2);
`else
    check("frm_total", frm_cnt, 32'd1);
`endif

    tick(4);
    check("sb_drained", exp_q.size(), 32'd0);
    check("ovr_total", ovr_cnt, 32'd1);
    check("to_total", to_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
